// File: rtl/gpu_pkg.sv
// Shared GPU encodings: core FSM states, writeback source codes and the special
// register map used by every per-thread register file.
package gpu_pkg;

    localparam int unsigned REG_ADDR_BITS = 4;
    localparam int unsigned NUM_REGS      = 16;
    localparam int unsigned BLOCK_ID_BITS = 8;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_FETCH   = 3'b001;
    localparam logic [2:0] ST_DECODE  = 3'b010;
    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_WAIT    = 3'b100;
    localparam logic [2:0] ST_EXECUTE = 3'b101;
    localparam logic [2:0] ST_UPDATE  = 3'b110;
    localparam logic [2:0] ST_DONE    = 3'b111;

    localparam logic [1:0] MUX_ALU  = 2'b00;
    localparam logic [1:0] MUX_LSU  = 2'b01;
    localparam logic [1:0] MUX_IMM  = 2'b10;
    localparam logic [1:0] MUX_RSVD = 2'b11;

    localparam logic [3:0] REG_BLOCK_ID  = 4'd13;
    localparam logic [3:0] REG_BLOCK_DIM = 4'd14;
    localparam logic [3:0] REG_THREAD_ID = 4'd15;
    localparam logic [3:0] REG_FIRST_RO  = 4'd13;

    function automatic logic is_read_only(input logic [3:0] addr);
        return addr >= REG_FIRST_RO;
    endfunction

endpackage

// File: rtl/thread_regfile_if.sv
// Decode/alu/lsu-side bundle of a thread register file; master is the core side.
interface thread_regfile_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 enable;
    logic [7:0]           block_id;
    logic [2:0]           core_state;
    logic [3:0]           decoded_rd_address;
    logic [3:0]           decoded_rs_address;
    logic [3:0]           decoded_rt_address;
    logic                 decoded_reg_write_enable;
    logic [1:0]           decoded_reg_input_mux;
    logic [7:0]           decoded_immediate;
    logic [DATA_BITS-1:0] alu_out;
    logic [DATA_BITS-1:0] lsu_out;
    logic [DATA_BITS-1:0] rs;
    logic [DATA_BITS-1:0] rt;
    logic                 wr_protect_err;

    modport master (
        output enable, block_id, core_state,
        output decoded_rd_address, decoded_rs_address, decoded_rt_address,
        output decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        output alu_out, lsu_out,
        input  rs, rt, wr_protect_err
    );

    modport slave (
        input  enable, block_id, core_state,
        input  decoded_rd_address, decoded_rs_address, decoded_rt_address,
        input  decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        input  alu_out, lsu_out,
        output rs, rt, wr_protect_err
    );
endinterface

// File: rtl/thread_regfile_wb_mux.sv
// Writeback source select plus qualification: decides whether UPDATE commits to rd
// or trips the read-only protection flag.
module regfile_wb_mux
    import gpu_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic [2:0]           core_state,
    input  logic                 write_enable,
    input  logic [1:0]           input_mux,
    input  logic [3:0]           rd_address,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    input  logic [DATA_BITS-1:0] immediate,
    output logic [DATA_BITS-1:0] wr_data_c,
    output logic                 wr_valid_c,
    output logic                 protect_err_c
);

    logic src_ok;
    logic commit;

    always_comb begin
        wr_data_c     = '0;
        src_ok        = 1'b1;
        commit        = 1'b0;
        wr_valid_c    = 1'b0;
        protect_err_c = 1'b0;

        case (input_mux)
            MUX_ALU: wr_data_c = alu_out;
            MUX_LSU: wr_data_c = lsu_out;
            MUX_IMM: wr_data_c = immediate;
            default: src_ok    = 1'b0;
        endcase

        // Reserved source is a silent no-op: neither a write nor a protection hit.
        commit        = (core_state == ST_UPDATE) && write_enable && src_ok;
        wr_valid_c    = commit && !is_read_only(rd_address);
        protect_err_c = commit && is_read_only(rd_address);
    end

endmodule

// File: rtl/thread_regfile.sv
// Per-thread register file: operand read in REQUEST, writeback in UPDATE,
// read-only block id / block dim / thread id in R13..R15.
module thread_regfile
    import gpu_pkg::*;
#(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned THREAD_ID         = 0,
    parameter int unsigned DATA_BITS         = 8
) (
    input logic              clk,
    input logic              reset,
    thread_regfile_if.slave  bus
);

    logic [DATA_BITS-1:0] regs [NUM_REGS];
    logic [DATA_BITS-1:0] wr_data_c;
    logic                 wr_valid_c;
    logic                 protect_err_c;

    regfile_wb_mux #(
        .DATA_BITS (DATA_BITS)
    ) u_wb_mux (
        .core_state    (bus.core_state),
        .write_enable  (bus.decoded_reg_write_enable),
        .input_mux     (bus.decoded_reg_input_mux),
        .rd_address    (bus.decoded_rd_address),
        .alu_out       (bus.alu_out),
        .lsu_out       (bus.lsu_out),
        .immediate     (DATA_BITS'(bus.decoded_immediate)),
        .wr_data_c     (wr_data_c),
        .wr_valid_c    (wr_valid_c),
        .protect_err_c (protect_err_c)
    );

    // Register array; R13 mirrors block_id every enabled cycle, so a same-cycle
    // read of R13 sees the value from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            regs[REG_BLOCK_DIM] <= DATA_BITS'(THREADS_PER_BLOCK);
            regs[REG_THREAD_ID] <= DATA_BITS'(THREAD_ID);
        end else if (bus.enable) begin
            regs[REG_BLOCK_ID] <= DATA_BITS'(bus.block_id);
            if (wr_valid_c) begin
                regs[bus.decoded_rd_address] <= wr_data_c;
            end
        end
    end

    // Operand latch: only REQUEST loads rs/rt, every other state holds them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rs <= '0;
            bus.rt <= '0;
        end else if (bus.enable && (bus.core_state == ST_REQUEST)) begin
            bus.rs <= regs[bus.decoded_rs_address];
            bus.rt <= regs[bus.decoded_rt_address];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.wr_protect_err <= 1'b0;
        end else if (bus.enable && protect_err_c) begin
            bus.wr_protect_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_thread_regfile.sv
// Directed bench for thread_regfile: operand reads, writeback sources, protection
// flag, enable gating, R13 refresh timing and asynchronous reset.
module tb_thread_regfile;
    import gpu_pkg::*;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned TPB       = 4;
    localparam int unsigned TID       = 2;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    thread_regfile_if #(.DATA_BITS(DATA_BITS)) bus ();

    thread_regfile #(
        .THREADS_PER_BLOCK (TPB),
        .THREAD_ID         (TID),
        .DATA_BITS         (DATA_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic [2:0] st);
        bus.core_state = st;
        @(posedge clk);
        #1;
    endtask

    task automatic update(input logic [3:0] rd, input logic we, input logic [1:0] mux,
                          input logic [7:0] alu, input logic [7:0] lsu, input logic [7:0] imm);
        bus.decoded_rd_address       = rd;
        bus.decoded_reg_write_enable = we;
        bus.decoded_reg_input_mux    = mux;
        bus.alu_out                  = alu;
        bus.lsu_out                  = lsu;
        bus.decoded_immediate        = imm;
        cycle(ST_UPDATE);
        bus.decoded_reg_write_enable = 1'b0;
        bus.core_state               = ST_IDLE;
    endtask

    task automatic request(input logic [3:0] rs_a, input logic [3:0] rt_a);
        bus.decoded_rs_address = rs_a;
        bus.decoded_rt_address = rt_a;
        cycle(ST_REQUEST);
        bus.core_state = ST_IDLE;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.enable                   = 1'b1;
        bus.block_id                 = 8'd0;
        bus.core_state               = ST_IDLE;
        bus.decoded_rd_address       = 4'd0;
        bus.decoded_rs_address       = 4'd0;
        bus.decoded_rt_address       = 4'd0;
        bus.decoded_reg_write_enable = 1'b0;
        bus.decoded_reg_input_mux    = MUX_ALU;
        bus.decoded_immediate        = 8'd0;
        bus.alu_out                  = 8'd0;
        bus.lsu_out                  = 8'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_rs", 32'(bus.rs), 32'h0);
        check("reset_rt", 32'(bus.rt), 32'h0);
        check("reset_err", 32'(bus.wr_protect_err), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cycle(ST_IDLE);

        request(4'd15, 4'd14);
        check("req_tid", 32'(bus.rs), 32'(TID));
        check("req_tpb", 32'(bus.rt), 32'(TPB));
        check("req_err0", 32'(bus.wr_protect_err), 32'h0);

        update(4'd3, 1'b1, MUX_ALU, 8'h5A, 8'hEE, 8'hDD);
        cycle(ST_EXECUTE);
        request(4'd3, 4'd0);
        check("alu_wr", 32'(bus.rs), 32'h5A);
        check("r0_zero", 32'(bus.rt), 32'h0);

        update(4'd4, 1'b1, MUX_IMM, 8'h11, 8'h22, 8'hC3);
        request(4'd4, 4'd3);
        check("imm_wr", 32'(bus.rs), 32'hC3);
        check("imm_r3", 32'(bus.rt), 32'h5A);

        update(4'd5, 1'b1, MUX_LSU, 8'h00, 8'h3C, 8'h00);
        request(4'd5, 4'd5);
        check("lsu_rs", 32'(bus.rs), 32'h3C);
        check("lsu_rt_same", 32'(bus.rt), 32'h3C);

        // Suppressed writes: reserved source and write_enable low
        update(4'd3, 1'b1, MUX_RSVD, 8'h99, 8'h98, 8'h97);
        update(4'd3, 1'b0, MUX_ALU, 8'h77, 8'h76, 8'h75);
        request(4'd3, 4'd4);
        check("nowr_r3", 32'(bus.rs), 32'h5A);
        check("nowr_r4", 32'(bus.rt), 32'hC3);
        check("rsvd_noerr", 32'(bus.wr_protect_err), 32'h0);

        // Operands hold outside REQUEST even as addresses change
        bus.decoded_rs_address = 4'd15;
        bus.decoded_rt_address = 4'd14;
        cycle(ST_EXECUTE);
        cycle(ST_WAIT);
        check("hold_rs", 32'(bus.rs), 32'h5A);
        check("hold_rt", 32'(bus.rt), 32'hC3);

        // R13 read in the refresh cycle sees the pre-edge value
        bus.block_id = 8'd7;
        cycle(ST_IDLE);
        bus.block_id = 8'd8;
        request(4'd13, 4'd0);
        check("r13_preedge", 32'(bus.rs), 32'h7);
        request(4'd13, 4'd0);
        check("r13_new", 32'(bus.rs), 32'h8);

        update(4'd14, 1'b1, MUX_LSU, 8'h00, 8'h77, 8'h00);
        check("prot_set", 32'(bus.wr_protect_err), 32'h1);
        request(4'd14, 4'd15);
        check("prot_r14", 32'(bus.rs), 32'(TPB));
        check("prot_r15", 32'(bus.rt), 32'(TID));

        for (int i = 1; i <= 10; i++) begin
            update(4'd1, 1'b1, MUX_ALU, 8'(i * 16 + 1), 8'h00, 8'h00);
            request(4'd1, 4'd13);
            check("loop_r1", 32'(bus.rs), 32'(i * 16 + 1));
            check("prot_sticky", 32'(bus.wr_protect_err), 32'h1);
        end

        // Disabled thread: no writes, no R13 refresh, no operand update
        bus.enable   = 1'b0;
        bus.block_id = 8'd9;
        update(4'd2, 1'b1, MUX_ALU, 8'h11, 8'h00, 8'h00);
        request(4'd2, 4'd2);
        check("dis_rs_hold", 32'(bus.rs), 32'hA1);
        bus.enable = 1'b1;
        request(4'd13, 4'd2);
        check("dis_r13", 32'(bus.rs), 32'h8);
        check("dis_r2", 32'(bus.rt), 32'h0);
        request(4'd13, 4'd3);
        check("en_r13", 32'(bus.rs), 32'h9);
        check("en_r3", 32'(bus.rt), 32'h5A);

        // Asynchronous reset while an R5 write is pending
        bus.decoded_rd_address       = 4'd5;
        bus.decoded_reg_write_enable = 1'b1;
        bus.decoded_reg_input_mux    = MUX_IMM;
        bus.decoded_immediate        = 8'h55;
        bus.core_state               = ST_UPDATE;
        #2;
        reset = 1'b1;
        #1;
        check("arst_rs", 32'(bus.rs), 32'h0);
        check("arst_rt", 32'(bus.rt), 32'h0);
        check("arst_err", 32'(bus.wr_protect_err), 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.decoded_reg_write_enable = 1'b0;
        bus.core_state               = ST_IDLE;
        reset = 1'b0;
        cycle(ST_IDLE);
        request(4'd5, 4'd14);
        check("arst_r5", 32'(bus.rs), 32'h0);
        check("arst_r14", 32'(bus.rt), 32'(TPB));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
